// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, supported
// opcodes, and the ALU / mux select codes driven onto the datapath.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_SLT   = 3'd3;
  localparam logic [2:0] ALU_AND   = 3'd4;
  localparam logic [2:0] ALU_FUNCT = 3'd5;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_REGB  = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode classifier: turns an opcode into the instruction
// class flags the controller FSM steers on.
module mc_op_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output logic           is_r,
  output logic           is_lw,
  output logic           is_sw,
  output logic           is_br,
  output logic           is_bne,
  output logic           is_imm,
  output logic           is_zext,
  output logic           is_j,
  output logic           valid
);

  logic w_beq;
  logic w_addi;

  assign is_r    = (opcode == OPW'(OP_R));
  assign is_lw   = (opcode == OPW'(OP_LW));
  assign is_sw   = (opcode == OPW'(OP_SW));
  assign w_beq   = (opcode == OPW'(OP_BEQ));
  assign is_bne  = (opcode == OPW'(OP_BNE));
  assign w_addi  = (opcode == OPW'(OP_ADDI));
  assign is_zext = (opcode == OPW'(OP_ORI));
  assign is_j    = (opcode == OPW'(OP_J));

  assign is_br  = w_beq | is_bne;
  assign is_imm = w_addi | is_zext;
  assign valid  = is_r | is_lw | is_sw | is_br | is_imm | is_j;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Five-state multi-cycle CPU controller (FETCH/DECODE/EXEC/MEM/WB) producing
// datapath enables and selects from the state and the latched opcode.
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FW  = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           ir_we,
  output logic           pc_we,
  output logic [1:0]     pc_src,
  output logic           ext_op,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [2:0]     alu_op,
  output logic           reg_we,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           illegal,
  output logic [2:0]     state_o
);

  state_t         r_state;
  state_t         w_next;
  logic [OPW-1:0] r_opcode;
  logic [OPW-1:0] w_decOp;
  logic w_isR, w_isLw, w_isSw, w_isBr, w_isBne, w_isImm, w_isZext, w_isJ, w_valid;
  logic w_unused;

  // funct is consumed by the ALU decoder downstream, not by this FSM
  assign w_unused = ^funct;

  // The IR is only loaded at the end of FETCH, so DECODE classifies the live
  // opcode; later states use the copy latched on leaving DECODE.
  assign w_decOp = (r_state == DECODE) ? opcode : r_opcode;

  mc_op_decode #(.OPW(OPW)) u_dec (
    .opcode  (w_decOp),
    .is_r    (w_isR),
    .is_lw   (w_isLw),
    .is_sw   (w_isSw),
    .is_br   (w_isBr),
    .is_bne  (w_isBne),
    .is_imm  (w_isImm),
    .is_zext (w_isZext),
    .is_j    (w_isJ),
    .valid   (w_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FETCH;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_opcode <= opcode;
    end
  end

  assign state_o = rst ? 3'd0 : r_state;

  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    ext_op     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    if (rst) begin
      // Reset presents the FETCH selects with every request held off
      alu_src_b = SRCB_FOUR;
      w_next    = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            pc_we  = 1'b1;
            ir_we  = 1'b1;
            w_next = DECODE;
          end
        end
        DECODE: begin
          alu_src_b = SRCB_IMMSH;
          ext_op    = 1'b1;
          if (w_valid) begin
            w_next = EXEC;
          end else begin
            illegal = 1'b1;
            w_next  = FETCH;
          end
        end
        EXEC: begin
          w_next = FETCH;
          if (w_isR) begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
            w_next    = WB;
          end else if (w_isLw || w_isSw || (w_isImm && !w_isZext)) begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            ext_op    = 1'b1;
            w_next    = w_isImm ? WB : MEM;
          end else if (w_isZext) begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_OR;
            w_next    = WB;
          end else if (w_isBr) begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = PC_ALUOUT;
            pc_we     = w_isBne ? !zero : zero;
          end else if (w_isJ) begin
            pc_src = PC_JUMP;
            pc_we  = 1'b1;
          end
        end
        MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = w_isSw;
          if (mem_ready) w_next = w_isSw ? FETCH : WB;
        end
        WB: begin
          reg_we     = 1'b1;
          reg_dst    = w_isR;
          mem_to_reg = w_isLw;
          w_next     = FETCH;
        end
        default: w_next = FETCH;
      endcase
    end
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- OPW, 6, opcode field width.
- FW, 6, funct field width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock; all state changes on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- opcode, in, OPW, instr[31:26], taken from the instruction register.
- funct, in, FW, instr[5:0].
- zero, in, 1, ALU zero flag.
- mem_ready, in, 1, memory access done this cycle.
- mem_req, out, 1, memory access request.
- mem_we, out, 1, store when mem_req is high.
- iord, out, 1, memory address mux: 0 = PC, 1 = ALUOut.
- ir_we, out, 1, instruction register load.
- pc_we, out, 1, PC load.
- pc_src, out, 2, PC source: 0 = ALU, 1 = ALUOut (branch), 2 = jump target.
- ext_op, out, 1, immediate extender mode: 1 = sign, 0 = zero.
- alu_src_a, out, 1, ALU A input: 0 = PC, 1 = regA.
- alu_src_b, out, 2, ALU B input: 0 = regB, 1 = constant 4, 2 = ext imm, 3 = ext imm<<2.
- alu_op, out, 3, 0 = add, 1 = sub, 2 = or, 3 = slt, 4 = and, 5 = funct-decoded.
- reg_we, out, 1, register file write.
- reg_dst, out, 1, write register: 0 = rt, 1 = rd.
- mem_to_reg, out, 1, write-back source: 0 = ALUOut, 1 = MDR.
- illegal, out, 1, one-cycle pulse on an undecodable opcode.
- state_o, out, 3, current state, for debug.

Function
REQ-003 States SHALL be FETCH, DECODE, EXEC, MEM, WB.
REQ-004 Every output SHALL be a Moore function of state and the latched opcode, except pc_we in EXEC for branches (depends on zero).
REQ-005 FETCH SHALL drive mem_req=1, iord=0, alu_src_a=0, alu_src_b=1 and alu_op=add.
- pc_we and ir_we SHALL be asserted only in the cycle mem_ready=1.
- On mem_ready the FSM SHALL go to DECODE; otherwise it SHALL hold FETCH with all request outputs stable.
REQ-006 DECODE SHALL last exactly one cycle.
- Outputs: alu_src_a=0, alu_src_b=3, ext_op=1, alu_op=add (branch target into ALUOut).
- The opcode SHALL be latched internally.
- Next state: EXEC for a supported opcode; otherwise illegal=1 for that cycle and next state FETCH.
REQ-007 Supported opcodes SHALL be: R 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, ori 0x0D, j 0x02.
REQ-008 EXEC SHALL behave per opcode:
- R: alu_src_a=1, alu_src_b=0, alu_op=5; next WB.
- lw/sw/addi: alu_src_a=1, alu_src_b=2, ext_op=1, alu_op=add; next MEM for lw/sw, WB for addi.
- ori: alu_src_a=1, alu_src_b=2, ext_op=0, alu_op=or; next WB.
- beq/bne: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_src=1; pc_we = zero (beq) or !zero (bne); next FETCH.
- j: pc_src=2, pc_we=1; next FETCH.
REQ-009 MEM SHALL drive mem_req=1, iord=1, and mem_we=1 for sw.
- Hold MEM until mem_ready.
- Then: sw goes to FETCH; lw goes to WB.
REQ-010 WB SHALL drive reg_we=1 for exactly one cycle, then go to FETCH.
- R: reg_dst=1, mem_to_reg=0.
- addi/ori: reg_dst=0, mem_to_reg=0.
- lw: reg_dst=0, mem_to_reg=1.
REQ-011 Cycle counts assuming zero-wait memory (mem_ready=1 on first request cycle) SHALL be:
- R/addi/ori: 4.
- lw: 5.
- sw: 4.
- beq/bne/j: 3.
- Each memory wait cycle SHALL add exactly one cycle.
REQ-012 Outside the cases listed above, every write enable (pc_we, ir_we, reg_we, mem_we) and mem_req SHALL be 0, and every select SHALL be 0.
REQ-013 mem_ready SHALL be ignored in DECODE, EXEC and WB.

Reset
REQ-014 rst=1 at a clock edge SHALL force state FETCH and clear the latched opcode to 0, from any state, including mid-MEM wait.
REQ-015 While rst=1, all outputs SHALL be 0 except those defined for FETCH with mem_ready ignored: mem_req=0, pc_we=0, ir_we=0, illegal=0.
REQ-016 The first cycle after rst deasserts SHALL be FETCH with mem_req=1.

Structure
REQ-017 A shared package mc_ctrl_pkg SHALL hold:
- the state encoding (FETCH=0 … WB=4);
- the opcode constants;
- the alu_op and pc_src/alu_src_b encodings.
REQ-018 A combinational sub-module mc_op_decode SHALL map the latched opcode to the class flags is_r, is_lw, is_sw, is_br, is_bne, is_imm, is_zext, is_j and valid.
REQ-019 The FSM state register SHALL be the only sequential storage besides the latched opcode.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset, then R-type (op 0x00, funct 0x20), mem_ready tied 1 -> states F,D,E,W,F; reg_we=1 with reg_dst=1 in cycle 4 only.
- lw (0x23) with 2 wait cycles in FETCH and 1 in MEM -> 8 cycles total; mem_to_reg=1 in WB; pc_we exactly once.
- beq (0x04) with zero=1, then zero=0 -> pc_we=1 with pc_src=1 in the first EXEC; 0 in the second.
- ori (0x0D) -> ext_op=0 in EXEC; addi (0x08) -> ext_op=1.
- Opcode 0x3F -> illegal pulses 1 cycle in DECODE, next state FETCH, no write enables.
- rst asserted during a MEM wait of sw -> mem_we drops next cycle, state FETCH, no reg_we.
